// File: rtl/mem_stage_ctrl.sv
// MEM-stage load/store sequencer; MEM_TIMEOUT_EN adds a request-timeout abort with a sticky memErr.
// Latency: 1 cycle to WB registers for ALU ops and zero-wait accesses, otherwise until the memAck edge.
// Backpressure: stallMEM freezes the upstream pipeline combinationally while a request waits for memAck.
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       memReadMEM,
    input  logic       memWriteMEM,
    input  logic       memToRegMEM,
    input  logic       regWriteMEM,
    input  logic [7:0] aluResMEM,
    input  logic [7:0] writeDataMEM,
    input  logic [2:0] rdMEM,
    output logic       memReq,
    output logic       memWe,
    output logic [7:0] memAddr,
    output logic [7:0] memWdata,
    input  logic [7:0] memRdata,
    input  logic       memAck,
    output logic       stallMEM,
    output logic       memToRegWB,
    output logic       regWriteWB,
    output logic [7:0] aluResWB,
    output logic [7:0] readDataWB,
    output logic [2:0] rdWB,
    output logic       memErr
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    if ((TIMEOUT_CYCLES >> CNT_W) != 0) begin : gCntTooNarrow
        $error("CNT_W too narrow to hold TIMEOUT_CYCLES");
    end

    state_t state;
    logic   access;
    logic   isRead;
    logic   abort;

    assign access   = memReadMEM | memWriteMEM;
    // A simultaneous read+write is executed as a store, so no load data is captured.
    assign isRead   = memReadMEM & ~memWriteMEM;
    assign memReq   = rst & ((state == WAIT) | access);
    assign memWe    = memWriteMEM;
    assign memAddr  = aluResMEM;
    assign memWdata = writeDataMEM;
    assign stallMEM = memReq & ~memAck & ~abort;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] waitCnt;

    // waitCnt holds the number of earlier unacknowledged request cycles of this transfer.
    assign abort = rst & (state == WAIT) & ~memAck & (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt <= '0;
            memErr  <= 1'b0;
        end else begin
            waitCnt <= stallMEM ? waitCnt + 1'b1 : '0;
            if (abort) begin
                memErr <= 1'b1;
            end
        end
    end
`else
    assign abort  = 1'b0;
    assign memErr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            memToRegWB <= 1'b0;
            regWriteWB <= 1'b0;
            aluResWB   <= '0;
            readDataWB <= '0;
            rdWB       <= '0;
        end else if (stallMEM) begin
            // Bubble into write-back while the access is outstanding.
            state      <= WAIT;
            memToRegWB <= 1'b0;
            regWriteWB <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            memToRegWB <= 1'b0;
            regWriteWB <= 1'b0;
            readDataWB <= 8'hFF;
        end else begin
            state      <= IDLE;
            memToRegWB <= memToRegMEM;
            regWriteWB <= regWriteMEM;
            aluResWB   <= aluResMEM;
            rdWB       <= rdMEM;
            if (memReq && memAck && isRead) begin
                readDataWB <= memRdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized scoreboard bench for mem_stage_ctrl; expectations come from an op-level model.
module tb_mem_stage_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 16;
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       memReadMEM = 1'b0, memWriteMEM = 1'b0, memToRegMEM = 1'b0, regWriteMEM = 1'b0;
    logic [7:0] aluResMEM = '0, writeDataMEM = '0, memRdata = '0;
    logic [2:0] rdMEM = '0;
    logic       memAck = 1'b0;
    logic       memReq, memWe, stallMEM, memToRegWB, regWriteWB, memErr;
    logic [7:0] memAddr, memWdata, aluResWB, readDataWB;
    logic [2:0] rdWB;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .memReadMEM(memReadMEM), .memWriteMEM(memWriteMEM),
        .memToRegMEM(memToRegMEM), .regWriteMEM(regWriteMEM),
        .aluResMEM(aluResMEM), .writeDataMEM(writeDataMEM), .rdMEM(rdMEM),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memAck(memAck), .stallMEM(stallMEM),
        .memToRegWB(memToRegWB), .regWriteWB(regWriteWB), .aluResWB(aluResWB),
        .readDataWB(readDataWB), .rdWB(rdWB), .memErr(memErr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       m2r;
        logic       rw;
        logic [7:0] alu;
        logic [7:0] rdat;
        logic [2:0] rd;
        logic       err;
    } wb_t;

    typedef struct {
        logic       stall;
        logic       req;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        wb_t        wb;
    } rec_t;

    rec_t sb[$];
    wb_t  model;
    int   nChk  = 0;
    int   nFail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkWb(input string tag, input wb_t e);
        chk({tag, ".memToRegWB"}, 32'(memToRegWB), 32'(e.m2r));
        chk({tag, ".regWriteWB"}, 32'(regWriteWB), 32'(e.rw));
        chk({tag, ".aluResWB"},   32'(aluResWB),   32'(e.alu));
        chk({tag, ".readDataWB"}, 32'(readDataWB), 32'(e.rdat));
        chk({tag, ".rdWB"},       32'(rdWB),       32'(e.rd));
        chk({tag, ".memErr"},     32'(memErr),     32'(e.err));
    endtask

    // Monitor: comb outputs checked mid-cycle, WB state checked one cycle later.
    initial begin
        rec_t r;
        wb_t  pend;
        bit   hasPend;
        hasPend = 1'b0;
        forever begin
            @(negedge clk);
            if (hasPend) begin
                chkWb("wb", pend);
                hasPend = 1'b0;
            end
            if (sb.size() > 0) begin
                r = sb.pop_front();
                chk("stallMEM", 32'(stallMEM), 32'(r.stall));
                chk("memReq",   32'(memReq),   32'(r.req));
                if (r.req) begin
                    chk("memWe",    32'(memWe),    32'(r.we));
                    chk("memAddr",  32'(memAddr),  32'(r.addr));
                    chk("memWdata", 32'(memWdata), 32'(r.wdata));
                end
                pend    = r.wb;
                hasPend = 1'b1;
            end
        end
    end

    // kind: 0 ALU, 1 load, 2 store, 3 read+write (acts as store). lat: request cycle carrying memAck.
    task automatic issue(input int kind, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [2:0] rd, input logic m2r, input logic rw,
                         input int lat, input logic [7:0] rdata, input logic spur);
        rec_t r;
        bit   timedOut;
        memReadMEM   = (kind == 1) || (kind == 3);
        memWriteMEM  = (kind >= 2);
        aluResMEM    = addr;
        writeDataMEM = wdata;
        rdMEM        = rd;
        memToRegMEM  = m2r;
        regWriteMEM  = rw;
        memRdata     = rdata;
        r.we    = (kind >= 2);
        r.addr  = addr;
        r.wdata = wdata;
        if (kind == 0) begin
            memAck    = spur;
            model.m2r = m2r;
            model.rw  = rw;
            model.alu = addr;
            model.rd  = rd;
            r.stall = 1'b0;
            r.req   = 1'b0;
            r.wb    = model;
            sb.push_back(r);
            @(posedge clk); #1;
        end else begin
            for (int c = 1; c <= 64; c++) begin
                memAck   = (c == lat);
                timedOut = TO_EN && (c == TO) && (c != lat);
                r.req    = 1'b1;
                r.stall  = (c != lat) && !timedOut;
                if (r.stall) begin
                    model.m2r = 1'b0;
                    model.rw  = 1'b0;
                end else if (timedOut) begin
                    model.m2r  = 1'b0;
                    model.rw   = 1'b0;
                    model.rdat = 8'hFF;
                    model.err  = 1'b1;
                end else begin
                    model.m2r = m2r;
                    model.rw  = rw;
                    model.alu = addr;
                    model.rd  = rd;
                    if (kind == 1) model.rdat = rdata;
                end
                r.wb = model;
                sb.push_back(r);
                @(posedge clk); #1;
                if (!r.stall) break;
            end
        end
        memAck = 1'b0;
    endtask

    initial begin
        // Reset with a load pending: request and stall must stay low.
        memReadMEM = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.memReq", 32'(memReq), 32'd0);
        chk("rst.stallMEM", 32'(stallMEM), 32'd0);
        chkWb("rst", '0);
        memReadMEM = 1'b0;
        rst   = 1'b1;
        model = '0;

        issue(0, 8'h3C, 8'h00, 3'd5, 1'b0, 1'b1, 0, 8'h00, 1'b0);
        issue(1, 8'h10, 8'h00, 3'd3, 1'b1, 1'b1, 3, 8'hA5, 1'b0);
        issue(2, 8'h20, 8'h77, 3'd1, 1'b0, 1'b0, 1, 8'h00, 1'b0);
        issue(1, 8'h21, 8'h00, 3'd2, 1'b1, 1'b1, 1, 8'h5C, 1'b0);
`ifdef MEM_TIMEOUT_EN
        issue(1, 8'h30, 8'h00, 3'd4, 1'b1, 1'b1, 100, 8'h11, 1'b0);
`endif
        issue(0, 8'h44, 8'h00, 3'd6, 1'b0, 1'b1, 0, 8'hEE, 1'b1);

        for (int i = 0; i < 300; i++) begin
            issue(int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom), int'($urandom_range(1, TO_EN ? 6 : 5)),
                  8'($urandom), 1'($urandom));
        end

        // Reset two cycles into a load, then a late memAck while reset is held.
        memReadMEM  = 1'b1;
        memWriteMEM = 1'b0;
        aluResMEM   = 8'h40;
        memAck      = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("midwait.stallMEM", 32'(stallMEM), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort.memReq", 32'(memReq), 32'd0);
        chk("abort.stallMEM", 32'(stallMEM), 32'd0);
        chkWb("abort", '0);
        memAck   = 1'b1;
        memRdata = 8'h5A;
        @(posedge clk); #1;
        chk("lateack.readDataWB", 32'(readDataWB), 32'd0);
        chk("lateack.memReq", 32'(memReq), 32'd0);
        memAck     = 1'b0;
        memReadMEM = 1'b0;
        rst        = 1'b1;
        model      = '0;
        issue(0, 8'h99, 8'h00, 3'd7, 1'b0, 1'b1, 0, 8'h00, 1'b0);
        issue(1, 8'h9A, 8'h00, 3'd1, 1'b1, 1'b1, 2, 8'hC3, 1'b0);
        issue(0, 8'h9B, 8'h00, 3'd2, 1'b0, 1'b0, 0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
